pd_onchip_ram_pipelined: RTL

//  Parametrised single-port on-chip RAM behind an Avalon-MM slave. Generalises width and depth.

---
 rtl/pd_onchip_ram_pkg.sv | 22 ++
 rtl/pd_onchip_ram_if.sv | 29 ++
 rtl/pd_onchip_ram_core.sv | 32 +++
 rtl/pd_onchip_ram_pipelined.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pd_onchip_ram_pkg.sv
// Shared types and helpers for the pipelined on-chip RAM.
package pd_onchip_ram_pkg;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_e;

  localparam int DATA_W_DFLT = 32;
  localparam int LANES       = DATA_W_DFLT / 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  // Even parity for one byte lane: stored bit makes the 9-bit lane XOR to 0.
  function automatic logic lane_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/pd_onchip_ram_if.sv
// Avalon-MM slave bus for the on-chip RAM, plus clken/reset_req sidebands.
interface pd_onchip_ram_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                clken;
  logic                reset_req;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;
  logic                init_done;
  logic                parity_err;

  modport master (
    output address, byteenable, chipselect, read, write, writedata, clken, reset_req,
    input  readdata, readdatavalid, waitrequest, init_done, parity_err
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata, clken, reset_req,
    output readdata, readdatavalid, waitrequest, init_done, parity_err
  );
endinterface

// File: rtl/pd_onchip_ram_core.sv
// Inferred single-port byte-lane RAM with registered read data and clock enable.
module pd_onchip_ram_core #(
  parameter  int DEPTH  = 1024,
  parameter  int ADDR_W = 10,
  parameter  int LANES  = 4,
  parameter  int LANE_W = 8,
  localparam int W      = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic              we,
  input  logic              re,
  input  logic [LANES-1:0]  be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      q
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (clken && we)
      for (int i = 0; i < LANES; i++)
        if (be[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];

  // q only moves on a read so it holds the last read word between pulses.
  always_ff @(posedge clk)
    if (reset)            q <= '0;
    else if (clken && re) q <= mem[addr];

endmodule

// File: rtl/pd_onchip_ram_pipelined.sv
// Avalon-MM on-chip RAM: post-reset scrub, pipelined reads (latency 1 or 2).
// Optional per-byte parity storage/check when PD_ONCHIP_RAM_PARITY_EN is defined.
module pd_onchip_ram_pipelined
  import pd_onchip_ram_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  pd_onchip_ram_if.slave bus
);

  localparam int NUM_LANES = DATA_W / 8;
`ifdef PD_ONCHIP_RAM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam int MEM_W = NUM_LANES * LANE_W;
  localparam int CNT_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);

  state_e               state;
  logic [CNT_W-1:0]     clr_cnt;
  logic                 en, clearing, in_range, accept, wr_acc, rd_acc;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 mem_we;
  logic [NUM_LANES-1:0] mem_be;
  logic [MEM_W-1:0]     wdata_enc, mem_wdata, q;
  logic [DATA_W-1:0]    rdata_raw, rdata1, rdata_out;
  logic [NUM_LANES-1:0] lane_err;
  logic                 oor_q, perr1, perr_out;
  logic [READ_LATENCY:1] vld_pipe;

  // Reset also blocks accept so no command lands while the scrub restarts.
  assign en              = bus.clken & ~bus.reset_req & ~reset;
  assign clearing        = (state == CLEAR);
  assign bus.waitrequest = clearing | ~en;
  assign in_range        = {1'b0, bus.address} < DEPTH_V;
  assign accept          = bus.chipselect & (bus.read | bus.write) & ~bus.waitrequest;
  assign wr_acc          = accept & bus.write;
  assign rd_acc          = accept & bus.read & ~bus.write;

  always_ff @(posedge clk)
    if (reset) begin
      state         <= CLEAR;
      clr_cnt       <= '0;
      bus.init_done <= 1'b0;
    end else if (en) begin
      case (state)
        CLEAR:
          if (clr_cnt == LAST) begin
            state         <= IDLE;
            bus.init_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wdata_enc[i*LANE_W +: 8] = bus.writedata[i*8 +: 8];
    assign rdata_raw[i*8 +: 8]      = q[i*LANE_W +: 8];
`ifdef PD_ONCHIP_RAM_PARITY_EN
    assign wdata_enc[i*LANE_W + 8]  = lane_par(bus.writedata[i*8 +: 8]);
    assign lane_err[i]              = lane_par(q[i*LANE_W +: 8]) ^ q[i*LANE_W + 8];
`else
    assign lane_err[i]              = 1'b0;
`endif
  end

  // The scrub owns the RAM port while clearing; all-zero data carries correct parity.
  assign mem_addr  = clearing ? ADDR_W'(clr_cnt) : bus.address;
  assign mem_we    = clearing | (wr_acc & in_range);
  assign mem_be    = clearing ? '1 : bus.byteenable;
  assign mem_wdata = clearing ? '0 : wdata_enc;

  pd_onchip_ram_core #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .LANES (NUM_LANES),
    .LANE_W(LANE_W)
  ) u_core (
    .clk  (clk),
    .reset(reset),
    .clken(en),
    .we   (mem_we),
    .re   (rd_acc),
    .be   (mem_be),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .q    (q)
  );

  // Out-of-range flag travels alongside q so the masked word also holds between reads.
  always_ff @(posedge clk)
    if (reset)       oor_q <= 1'b0;
    else if (rd_acc) oor_q <= ~in_range;

  assign rdata1 = oor_q ? '0 : rdata_raw;
  assign perr1  = ~oor_q & (|lane_err);

  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk)
      if (reset)   vld_pipe <= '0;
      else if (en) vld_pipe <= rd_acc;
    assign rdata_out = rdata1;
    assign perr_out  = perr1;
  end else begin : g_lat2
    logic [DATA_W-1:0] rd_q;
    logic              perr_q;
    always_ff @(posedge clk)
      if (reset)   vld_pipe <= '0;
      else if (en) vld_pipe <= {vld_pipe[1], rd_acc};
    always_ff @(posedge clk)
      if (reset) begin
        rd_q   <= '0;
        perr_q <= 1'b0;
      end else if (en && vld_pipe[1]) begin
        rd_q   <= rdata1;
        perr_q <= perr1;
      end
    assign rdata_out = rd_q;
    assign perr_out  = perr_q;
  end

  // A frozen pipeline keeps its valid bit; gating with en emits it exactly once on resume.
  assign bus.readdata      = rdata_out;
  assign bus.readdatavalid = vld_pipe[READ_LATENCY] & en;
  assign bus.parity_err    = bus.readdatavalid & perr_out;

endmodule
